multicycle_alu: RTL

- Parametrised, handshaked execute-stage ALU; next generation of the single-cycle combinational ALU.
- Adds registered output, valid/ready flow control, flush, and iterative multi-cycle MUL/DIV/REM units.
- Sits in EX. The hazard unit stalls IF/ID/EX while in_ready_o is low or the result is not yet consumed.

---
 rtl/multicycle_alu_pkg.sv | 29 ++
 rtl/multicycle_alu_if.sv | 29 ++
 rtl/multicycle_alu_iter_unit.sv | 86 ++++++++
 rtl/multicycle_alu.sv | 98 +++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// alu_pkg: shared constants, op codes, FSM states and op classification for multicycle_alu
// Contents: DEF_XLEN/DEF_CTRL_LEN defaults, OP_* codes, state_e, is_iterative()
package alu_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_CTRL_LEN = 4;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_XOR  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REM  = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: operand/result handshake bundle of the execute-stage ALU
// Issue side: flush_i, in_valid_i, in_ready_o, ALUCtrl_i, data1_i, data2_i
// Result side: out_valid_o, out_ready_i, data_o, Zero_o
// slave = the ALU, master = the pipeline driving it
interface multicycle_alu_if #(
    parameter int XLEN     = 32,
    parameter int CTRL_LEN = 4
);
    logic                flush_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [CTRL_LEN-1:0] ALUCtrl_i;
    logic [XLEN-1:0]     data1_i;
    logic [XLEN-1:0]     data2_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [XLEN-1:0]     data_o;
    logic                Zero_o;

    modport slave (
        input  flush_i, in_valid_i, ALUCtrl_i, data1_i, data2_i, out_ready_i,
        output in_ready_o, out_valid_o, data_o, Zero_o
    );

    modport master (
        output flush_i, in_valid_i, ALUCtrl_i, data1_i, data2_i, out_ready_i,
        input  in_ready_o, out_valid_o, data_o, Zero_o
    );
endinterface

// File: rtl/multicycle_alu_iter_unit.sv
// alu_iter_unit: shared radix-2 shift-add multiplier / restoring divider, XLEN steps per op
// Ports: clk_i, rst_i (async active-low), start_i (load operands), kill_i (abort),
//        op_i, a_i, b_i (operands sampled on start_i), done_o (one-cycle pulse), result_o
module alu_iter_unit import alu_pkg::*; #(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    // MUL: acc = product, part = remaining multiplier bits, opnd = shifted multiplicand
    // DIV: acc = partial remainder, part = dividend shifting out / quotient shifting in, opnd = divisor
    logic [XLEN-1:0] acc, part, opnd;
    logic [CW-1:0]   cnt;
    logic            busy, neg_q, neg_r;
    logic [3:0]      op_q;
    logic            sgn;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   shl, diff;

    assign sgn   = op_i == OP_DIV || op_i == OP_REM;
    assign mag_a = sgn && a_i[XLEN-1] ? -a_i : a_i;
    assign mag_b = sgn && b_i[XLEN-1] ? -b_i : b_i;
    // one extra bit so the trial subtraction's borrow says whether to restore
    assign shl   = {acc, part[XLEN-1]};
    assign diff  = shl - {1'b0, opnd};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc    <= '0;
            part   <= '0;
            opnd   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done_o <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            op_q   <= '0;
        end else if (kill_i) begin
            cnt    <= '0;
            busy   <= 1'b0;
            done_o <= 1'b0;
        end else if (start_i) begin
            acc    <= '0;
            part   <= op_i == OP_MUL ? b_i : mag_a;
            opnd   <= op_i == OP_MUL ? a_i : mag_b;
            cnt    <= CW'(XLEN - 1);
            busy   <= 1'b1;
            done_o <= 1'b0;
            neg_q  <= sgn && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            neg_r  <= sgn && a_i[XLEN-1];
            op_q   <= op_i;
        end else begin
            done_o <= busy && cnt == '0;
            if (busy) begin
                if (op_q == OP_MUL) begin
                    acc  <= part[0] ? acc + opnd : acc;
                    opnd <= opnd << 1;
                    part <= part >> 1;
                end else if (diff[XLEN]) begin
                    acc  <= shl[XLEN-1:0];
                    part <= {part[XLEN-2:0], 1'b0};
                end else begin
                    acc  <= diff[XLEN-1:0];
                    part <= {part[XLEN-2:0], 1'b1};
                end
                if (cnt == '0) busy <= 1'b0;
                else cnt <= cnt - 1'b1;
            end
        end
    end

    // sign fix-up applied to the magnitude result as it is handed over
    assign result_o = op_q == OP_MUL ? acc :
                      (op_q == OP_DIV || op_q == OP_DIVU) ? (neg_q ? -part : part) :
                      (neg_r ? -acc : acc);

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked execute-stage ALU with registered result and iterative MUL/DIV/REM
// Ports: clk_i, rst_i (async active-low), bus (multicycle_alu_if.slave: flush, issue
//        valid/ready, op and operands, result valid/ready, data_o, Zero_o)
module multicycle_alu import alu_pkg::*; #(
    parameter int XLEN     = DEF_XLEN,
    parameter int CTRL_LEN = DEF_CTRL_LEN,
    parameter int SHAMT_W  = $clog2(XLEN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_alu_if.slave  bus
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state, state_nx;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b, fast, iter_res;
    logic [SHAMT_W-1:0] sh;
    logic            is_div, div0, ovf, iter_path, accept, iter_start, iter_done;

    assign op = 4'(bus.ALUCtrl_i);
    assign a  = bus.data1_i;
    assign b  = bus.data2_i;
    assign sh = b[SHAMT_W-1:0];

    assign is_div    = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign div0      = is_div && b == '0;
    assign ovf       = (op == OP_DIV || op == OP_REM) && a == MIN_INT && b == '1;
    // divide-by-zero and signed overflow have fixed answers, so skip the iterative unit
    assign iter_path = is_iterative(op) && !div0 && !ovf;

    always_comb begin
        fast = '0;
        case (op)
            OP_AND:           fast = a & b;
            OP_OR:            fast = a | b;
            OP_XOR:           fast = a ^ b;
            OP_ADD:           fast = a + b;
            OP_SUB:           fast = a - b;
            OP_SLL:           fast = a << sh;
            OP_SRL:           fast = a >> sh;
            OP_SRA:           fast = $signed(a) >>> sh;
            OP_SLT:           fast = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_DIV, OP_DIVU:  fast = div0 ? '1 : a;
            OP_REM, OP_REMU:  fast = div0 ? a : '0;
            default:          fast = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else if (bus.flush_i) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (iter_path ? BUSY : DONE) : IDLE;
            BUSY:    state_nx = iter_done ? DONE : BUSY;
            DONE:    state_nx = accept ? (iter_path ? BUSY : DONE) : bus.out_ready_i ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o  = state == IDLE || (state == DONE && bus.out_ready_i);
        bus.out_valid_o = state == DONE;
        accept          = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
        iter_start      = accept && iter_path;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.data_o <= '0;
            bus.Zero_o <= 1'b0;
        end else if (accept && !iter_path) begin
            bus.data_o <= fast;
            bus.Zero_o <= fast == '0;
        end else if (state == BUSY && iter_done && !bus.flush_i) begin
            bus.data_o <= iter_res;
            bus.Zero_o <= iter_res == '0;
        end
    end

    alu_iter_unit #(.XLEN(XLEN)) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (iter_start),
        .kill_i   (bus.flush_i),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .done_o   (iter_done),
        .result_o (iter_res)
    );

endmodule
